eth_rx_packet_writer: RTL



---
 rtl/eth_rx_packet_writer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_packet_writer.sv
// Packs an RX byte stream little-endian into buffer words and commits each good packet to the packet FIFO.
// Optional statistics counters are enabled by defining ETH_RX_PACKET_WRITER_STATS_EN.
module eth_rx_packet_writer #(
  parameter int data_width_p = 64,
  parameter int els_p        = 2048
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              rx_valid_i,
  input  logic [7:0]                        rx_data_i,
  input  logic                              rx_last_i,
  input  logic                              rx_error_i,
  output logic                              rx_ready_o,
  input  logic                              packet_req_i,
  output logic                              packet_send_o,
  output logic                              packet_wsize_valid_o,
  output logic [$clog2(els_p+1)-1:0]        packet_wsize_o,
  output logic                              packet_wvalid_o,
  output logic [$clog2(els_p)-1:0]          packet_waddr_o,
  output logic [data_width_p-1:0]           packet_wdata_o,
  output logic [data_width_p/8-1:0]         packet_wmask_o
`ifdef ETH_RX_PACKET_WRITER_STATS_EN
  ,
  output logic [31:0]                       good_packets_o,
  output logic [31:0]                       dropped_packets_o
`endif
);

  localparam int lanes_lp     = data_width_p / 8;
  localparam int lane_bits_lp = $clog2(lanes_lp);
  localparam int cnt_w_lp     = $clog2(els_p + 1);
  localparam int addr_w_lp    = $clog2(els_p);

  typedef enum logic [1:0] {IDLE, RECV, DROP, COMMIT} state_e;

  state_e                    state_reg, state_next;
  logic [cnt_w_lp-1:0]       count_reg, count_next;
  logic [data_width_p-1:0]   word_reg, word_next, word_merged;
  logic                      wvalid_reg, wvalid_next;
  logic [addr_w_lp-1:0]      waddr_reg, waddr_next;
  logic [data_width_p-1:0]   wdata_reg, wdata_next;
  logic                      wsize_valid_reg, wsize_valid_next;
  logic [cnt_w_lp-1:0]       wsize_reg, wsize_next;
  logic                      send_reg, send_next;
  logic                      accept, store, drop_pulse;
  logic [lane_bits_lp-1:0]   lane;
  logic [addr_w_lp-1:0]      word_addr;

  assign rx_ready_o = (state_reg != COMMIT);
  assign accept     = rx_valid_i & rx_ready_o;
  assign lane       = count_reg[lane_bits_lp-1:0];
  assign word_addr  = {count_reg[addr_w_lp-1:lane_bits_lp], {lane_bits_lp{1'b0}}};

  // Incoming byte replaces its lane; other lanes keep earlier bytes of the same word.
  for (genvar gi = 0; gi < lanes_lp; gi++) begin : g_lane
    assign word_merged[gi*8 +: 8] = (int'(lane) == gi) ? rx_data_i : word_reg[gi*8 +: 8];
  end

  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    word_next        = word_reg;
    wvalid_next      = 1'b0;
    waddr_next       = waddr_reg;
    wdata_next       = wdata_reg;
    wsize_valid_next = 1'b0;
    wsize_next       = wsize_reg;
    send_next        = 1'b0;
    store            = 1'b0;
    drop_pulse       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (!packet_req_i || rx_error_i) begin
            drop_pulse = 1'b1;
            state_next = rx_last_i ? IDLE : DROP;
          end else begin
            store = 1'b1;
          end
        end
      end
      RECV: begin
        if (accept) begin
          // A byte arriving with the count already at capacity would overflow the slot.
          if (rx_error_i || count_reg == cnt_w_lp'(els_p)) begin
            drop_pulse = 1'b1;
            count_next = '0;
            state_next = rx_last_i ? IDLE : DROP;
          end else begin
            store = 1'b1;
          end
        end
      end
      DROP: begin
        if (accept && rx_last_i) begin
          count_next = '0;
          state_next = IDLE;
        end
      end
      COMMIT: begin
        count_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (store) begin
      word_next  = word_merged;
      count_next = cnt_w_lp'(count_reg + 1'b1);
      if (rx_last_i || lane == {lane_bits_lp{1'b1}}) begin
        wvalid_next = 1'b1;
        waddr_next  = word_addr;
        wdata_next  = word_merged;
      end
      if (rx_last_i) begin
        state_next       = COMMIT;
        wsize_valid_next = 1'b1;
        wsize_next       = cnt_w_lp'(count_reg + 1'b1);
        send_next        = 1'b1;
      end else begin
        state_next = RECV;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      word_reg        <= '0;
      wvalid_reg      <= 1'b0;
      waddr_reg       <= '0;
      wdata_reg       <= '0;
      wsize_valid_reg <= 1'b0;
      wsize_reg       <= '0;
      send_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      word_reg        <= word_next;
      wvalid_reg      <= wvalid_next;
      waddr_reg       <= waddr_next;
      wdata_reg       <= wdata_next;
      wsize_valid_reg <= wsize_valid_next;
      wsize_reg       <= wsize_next;
      send_reg        <= send_next;
    end
  end

  assign packet_send_o        = send_reg;
  assign packet_wsize_valid_o = wsize_valid_reg;
  assign packet_wsize_o       = wsize_reg;
  assign packet_wvalid_o      = wvalid_reg;
  assign packet_waddr_o       = waddr_reg;
  assign packet_wdata_o       = wdata_reg;
  assign packet_wmask_o       = '1;

`ifdef ETH_RX_PACKET_WRITER_STATS_EN
  logic [31:0] good_reg, dropped_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      good_reg    <= '0;
      dropped_reg <= '0;
    end else begin
      if (state_reg == COMMIT && good_reg != 32'hFFFF_FFFF) good_reg <= good_reg + 32'd1;
      if (drop_pulse && dropped_reg != 32'hFFFF_FFFF) dropped_reg <= dropped_reg + 32'd1;
    end
  end

  assign good_packets_o    = good_reg;
  assign dropped_packets_o = dropped_reg;
`endif

  // Only this block enqueues, so the slot cannot disappear mid-packet.
  a_req_held: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_reg == RECV || state_reg == COMMIT) |-> packet_req_i);

endmodule
